// File: rtl/sonic_key_sched_seq.sv
// Round-key sequencer: expands a 128-bit master key into NUM_ROUNDS 64-bit round keys under valid/ready.
// Optional feature macro SONIC_KS_CACHE_EN adds a round-key cache and a REPLAY state.
module sonic_key_sched_seq #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [63:0]  rk_out,
  output logic [5:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  input  logic         replay
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

`ifdef SONIC_KS_CACHE_EN
  typedef enum logic [1:0] {IDLE, RUN, REPLAY} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t        state_reg, state_next;
  logic [127:0]  s_reg, s_next;
  logic [5:0]    idx_reg, idx_next;
  logic          alive_reg;
  logic          key_load;

  // Update function U(S): linear mix for the new hi, bit permutation of t for the new lo.
  logic [63:0] hi, lo, rl1, y_val, t_val, x_val;
  assign hi    = s_reg[127:64];
  assign lo    = s_reg[63:0];
  assign rl1   = {lo[62:0], lo[63]};
  assign y_val = rl1 ^ {lo[55:0], lo[63:56]} ^ {lo[53:0], lo[63:54]};
  assign t_val = hi ^ rl1 ^ ({lo[51:0], lo[63:52]} & lo);

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_perm
      assign x_val[gi] = t_val[(15 * gi) % 64];
    end
  endgenerate

`ifdef SONIC_KS_CACHE_EN
  localparam int AW = $clog2(NUM_ROUNDS);
  logic [63:0] cache_mem [NUM_ROUNDS];
  logic [63:0] rd_data_reg;
  logic        cache_full_reg;
`else
  logic replay_unused;
  assign replay_unused = replay;
`endif

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    idx_next   = idx_reg;
    key_ready  = 1'b0;
    key_load   = 1'b0;
    rk_valid   = 1'b0;
    rk_out     = s_reg[63:0];
    case (state_reg)
      IDLE: begin
        key_ready = alive_reg;
`ifdef SONIC_KS_CACHE_EN
        // Replay wins over a new key; key_ready drops so no key is silently lost.
        if (alive_reg && replay && cache_full_reg) begin
          key_ready  = 1'b0;
          idx_next   = '0;
          state_next = REPLAY;
        end else
`endif
        if (alive_reg && key_valid) begin
          key_load   = 1'b1;
          s_next     = key_in;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        rk_valid = 1'b1;
        if (rk_ready) begin
          if (idx_reg == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            s_next   = {y_val, x_val};
            idx_next = idx_reg + 6'd1;
          end
        end
      end
`ifdef SONIC_KS_CACHE_EN
      REPLAY: begin
        rk_valid = 1'b1;
        rk_out   = rd_data_reg;
        if (rk_ready) begin
          if (idx_reg == LAST_IDX) state_next = IDLE;
          else                     idx_next   = idx_reg + 6'd1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign rk_idx  = idx_reg;
  assign rk_last = rk_valid && (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      idx_reg   <= '0;
      alive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      idx_reg   <= idx_next;
      alive_reg <= 1'b1;
    end
  end

`ifdef SONIC_KS_CACHE_EN
  // Read address follows idx_next so the registered read lines up with idx_reg.
  always_ff @(posedge clk) begin
    if (state_reg == RUN && rk_ready)
      cache_mem[idx_reg[AW-1:0]] <= s_reg[63:0];
    rd_data_reg <= cache_mem[idx_next[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cache_full_reg <= 1'b0;
    else if (key_load)
      cache_full_reg <= 1'b0;
    else if (state_reg == RUN && rk_ready && idx_reg == LAST_IDX)
      cache_full_reg <= 1'b1;
  end
`endif

endmodule

// File: doc/sonic_key_sched_seq.md
SONIC_KEY_SCHED_SEQ -- requirements
Module: sonic_key_sched_seq

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 16, giving the number of 64-bit round keys emitted per master key; the legal range is 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port key_in, input, 128 bits: master key, where [127:64] is hi and [63:0] is lo.
REQ-005 The block SHALL have port key_valid, input, 1 bit: master key offered.
REQ-006 The block SHALL have port key_ready, output, 1 bit: block able to accept a master key.
REQ-007 The block SHALL have port rk_out, output, 64 bits: current round key.
REQ-008 The block SHALL have port rk_idx, output, 6 bits: index of rk_out, counting 0..NUM_ROUNDS-1.
REQ-009 The block SHALL have port rk_valid, input direction output, 1 bit: rk_out and rk_idx are valid.
REQ-010 The block SHALL have port rk_ready, input, 1 bit: consumer (round datapath) accepts rk_out.
REQ-011 The block SHALL have port rk_last, output, 1 bit: asserted with rk_valid when rk_idx equals NUM_ROUNDS-1.
REQ-012 The block SHALL have port replay, input, 1 bit: request re-emission of the cached key sequence; it is used only under SONIC_KS_CACHE_EN.

Function
REQ-013 The block SHALL hold a 128-bit state register S = {hi, lo}.
REQ-014 The update function U(S) SHALL be defined as follows, where rotl(v,n) is a 64-bit rotate left:
  - y = rotl(lo,1) ^ rotl(lo,8) ^ rotl(lo,10)
  - t = hi ^ rotl(lo,1) ^ (rotl(lo,12) & lo)
  - x[i] = t[(15*i) mod 64] for i = 0..63
  - U(S) = {y, x}
REQ-015 The FSM SHALL have states IDLE, RUN and, only under the macro, REPLAY.
REQ-016 In IDLE, key_ready SHALL be 1 and rk_valid SHALL be 0.
REQ-017 On key_valid && key_ready, the block SHALL load S = key_in, set idx = 0, and move to RUN on the next cycle.
REQ-018 In RUN:
  - rk_valid SHALL be 1, rk_out SHALL equal S.lo, and rk_idx SHALL equal idx.
  - key_ready SHALL be 0; key_valid SHALL be ignored.
REQ-019 On an rk_valid && rk_ready handshake in RUN with idx < NUM_ROUNDS-1, the block SHALL set S = U(S) and idx = idx+1.
REQ-020 On a handshake with idx = NUM_ROUNDS-1, the block SHALL return to IDLE and leave S unchanged.
REQ-021 While rk_ready = 0, S, idx, rk_out and rk_idx SHALL hold stable (no drop, no advance).
REQ-022 Latency SHALL be one cycle from master-key acceptance to rk_valid with rk_idx = 0; thereafter the block SHALL sustain one round key per cycle under constant rk_ready = 1.
REQ-023 A key_valid asserted during RUN SHALL be back-pressured (key_ready = 0) until the cycle after the final handshake.

Reset
REQ-024 Asserting rst_n = 0 SHALL immediately force:
  - state to IDLE, S = 0 and idx = 0;
  - rk_valid = 0, rk_last = 0, rk_out = 0 and rk_idx = 0;
  - key_ready = 0 while reset is asserted, and 1 from the first clock after release.
REQ-025 A reset mid-sequence SHALL abandon the sequence; no partial keys SHALL be emitted after release.

Configuration
REQ-026 With macro SONIC_KS_CACHE_EN defined:
  - each handshaked rk_out SHALL be written into a NUM_ROUNDS x 64 cache at rk_idx.
  - replay = 1 in IDLE SHALL enter REPLAY only after a complete sequence is cached, and SHALL take priority over key_valid.
  - REPLAY SHALL emit the cache entries 0..NUM_ROUNDS-1 with the same handshake, rk_idx and rk_last rules as RUN, then return to IDLE.
  - the cache-complete flag SHALL be cleared by reset and by a new key load.
REQ-027 Without SONIC_KS_CACHE_EN:
  - there SHALL be no cache storage and no REPLAY state.
  - replay SHALL be ignored.

Verification
REQ-028 Scenario: key_in = 0, rk_ready = 1 -> 16 keys, all 0, rk_idx 0..15, rk_last only at idx 15, then key_ready = 1.
REQ-029 Scenario: key_in = {64'h0, 64'h1} -> rk0 = 64'h0000_0000_0000_0001, rk1 = 64'h0000_8000_0000_0000, rk2 = 64'h0100_8000_0041_0000.
REQ-030 Scenario: same key with rk_ready deasserted for 3 cycles at idx 1 -> rk_out held at 64'h0000_8000_0000_0000 with rk_idx = 1 throughout; the sequence is then unchanged.
REQ-031 Scenario: key_valid held high during RUN -> key_ready stays 0 and the sequence is unaffected; the second key is accepted in IDLE.
REQ-032 Scenario: rst_n pulsed low at idx 5 -> rk_valid = 0 immediately, outputs = 0, and after release a fresh key restarts at idx 0.
REQ-033 Scenario (SONIC_KS_CACHE_EN): after the REQ-029 sequence, replay = 1 -> identical 16 keys re-emitted; replay before any complete sequence -> ignored.
